// File: rtl/prog_sequencer.sv
// Program-flow sequencer: owns the PC and 16-entry jump LUT, handles the
// start/done handshake and stalls the core for multi-cycle data loads.
module prog_sequencer #(
  parameter int PC_W     = 10,
  parameter int LOAD_LAT = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            lut_wr_en,
  input  logic [3:0]      lut_wr_addr,
  input  logic [PC_W-1:0] lut_wr_data,
  input  logic            pc_jmp_en,
  input  logic [3:0]      lut_ptr,
  input  logic            mem_rd,
  input  logic            halt_instr,
  output logic [PC_W-1:0] pc_out,
  output logic            run,
  output logic            done,
  output logic [15:0]     cycles
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [1:0] LAT      = 2'(LOAD_LAT);
  localparam logic       STALL_EN = (LOAD_LAT > 0) ? 1'b1 : 1'b0;

  state_t          r_state;
  logic            r_ld_done;
  logic [1:0]      r_wait_cnt;
  logic [PC_W-1:0] r_pc;
  logic            r_done;
  logic [15:0]     r_cycles;
  logic [PC_W-1:0] r_lut [16];

  logic w_stall;
  logic w_run;

  // A load stalls only on its first presentation; the re-presented load commits.
  assign w_stall = mem_rd & STALL_EN & ~r_ld_done;

  // Commit enable is Mealy so the decoder can gate writes in the same cycle.
  always_comb begin
    w_run = 1'b0;
    case (r_state)
      S_RUN: begin
        if (halt_instr) begin
          w_run = 1'b1;
        end else if (w_stall) begin
          w_run = 1'b0;
        end else begin
          w_run = 1'b1;
        end
      end
      default: w_run = 1'b0;
    endcase
  end

  // Sequencer state, PC, LUT and cycle counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_ld_done  <= 1'b0;
      r_wait_cnt <= 2'd0;
      r_pc       <= '0;
      r_done     <= 1'b0;
      r_cycles   <= 16'd0;
      for (int i = 0; i < 16; i++) begin
        r_lut[i] <= '0;
      end
    end else begin
      if (lut_wr_en) begin
        r_lut[lut_wr_addr] <= lut_wr_data;
      end
      if ((r_state == S_RUN || r_state == S_WAIT) && r_cycles != 16'hFFFF) begin
        r_cycles <= r_cycles + 16'd1;
      end
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state  <= S_RUN;
            r_pc     <= '0;
            r_cycles <= 16'd0;
            r_done   <= 1'b0;
          end
        end
        S_RUN: begin
          r_ld_done <= 1'b0;
          if (halt_instr) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else if (w_stall) begin
            r_state    <= S_WAIT;
            r_wait_cnt <= LAT;
          end else if (pc_jmp_en) begin
            r_pc <= r_lut[lut_ptr];
          end else begin
            r_pc <= r_pc + PC_W'(1);
          end
        end
        S_WAIT: begin
          if (r_wait_cnt == 2'd1) begin
            r_state    <= S_RUN;
            r_ld_done  <= 1'b1;
            r_wait_cnt <= 2'd0;
          end else begin
            r_wait_cnt <= r_wait_cnt - 2'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign pc_out = r_pc;
  assign run    = w_run;
  assign done   = r_done;
  assign cycles = r_cycles;

endmodule

// File: doc/prog_sequencer.md
# prog_sequencer

Program-flow sequencer for the 9-bit core. It owns the program counter and the 16-entry jump-target LUT, and runs the start/done handshake with the testbench. It also stalls the pipeline for multi-cycle data-memory loads. It sits between instruction memory and the instruction decoder: it consumes the decoder's `pc_jmp_en`, `LutPointer` and load indication, and produces the fetch address plus a commit-enable that gates all architectural writes.

## Interface
- `PC_W`, 10: program counter width; instruction memory depth is 2^PC_W.
- `LOAD_LAT`, 1: extra wait cycles for a data-memory load, range 0..3.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high; clears all state immediately.
- `start` input 1: single-cycle request to run the program from address 0.
- `lut_wr_en` input 1: write enable for the jump LUT.
- `lut_wr_addr` input 4: LUT entry being written.
- `lut_wr_data` input PC_W: absolute jump target to store.
- `pc_jmp_en` input 1: take the jump this cycle (from the decoder, flags already resolved).
- `lut_ptr` input 4: LUT index selecting the jump target.
- `mem_rd` input 1: current instruction is a load (ldr/ldi).
- `halt_instr` input 1: current instruction is the halt encoding.
- `pc_out` output PC_W: fetch address; registered.
- `run` output 1: commit enable; the current instruction's register and memory writes take effect only when this is 1.
- `done` output 1: program finished; registered, held until the next accepted `start`.
- `cycles` output 16: count of RUN+WAIT cycles since the last accepted `start`; saturates at 0xFFFF.

## Operation
- Reset values: state=IDLE, `pc_out`=0, `done`=0, `run`=0, `cycles`=0, all 16 LUT entries=0, `ld_done`=0, wait counter=0.
- States are IDLE, RUN, WAIT and DONE.
- IDLE:
  - `run`=0; pc held.
  - `start` -> RUN, with pc=0, `cycles`=0, `done`=0.
- RUN:
  - `run` = !(`mem_rd` && LOAD_LAT>0 && !`ld_done`). This is combinational on `mem_rd`.
  - Priority, highest first:
    1. `halt_instr`: commit and go to DONE. `done`=1 next cycle; pc held at the halt address.
    2. Stalling load (`mem_rd`, LOAD_LAT>0, `ld_done`=0): go to WAIT with counter=LOAD_LAT; pc held.
    3. `pc_jmp_en`: pc = LUT[`lut_ptr`].
    4. Otherwise pc = pc+1, wrapping modulo 2^PC_W (max address -> 0).
  - `ld_done` clears on any RUN cycle in which it was 1.
- WAIT:
  - `run`=0; pc held; counter decrements each cycle.
  - When counter==1 -> RUN, with `ld_done`=1. The load instruction re-presents and commits with `run`=1.
- Load latency: a load occupies LOAD_LAT+2 cycles. With LOAD_LAT=0 `mem_rd` is ignored and a load takes 1 cycle.
- DONE:
  - `run`=0; `done`=1; pc held.
  - `start` -> RUN, with pc=0, `done`=0, `cycles`=0.
- `start` is ignored in RUN and WAIT.
- The LUT is writable in every state. On a same-cycle write and jump to the same entry, the jump uses the old value (read-before-write).
- `cycles` increments on every RUN or WAIT cycle, including the halt cycle. It stops in DONE/IDLE and saturates at 0xFFFF.
- `halt_instr` together with `pc_jmp_en`: halt wins; no jump.
- `halt_instr` together with a stalling `mem_rd`: halt wins; no stall.
- Reset asserted mid-run or mid-WAIT: immediate return to reset values, including LUT contents.

## Timing
- `pc_out`, `done` and `cycles` are registered and change only on a `clk` edge (or on `reset`).
- `run` is Mealy: a combinational function of state, `mem_rd`, `ld_done` and `halt_instr`. It is valid within the same cycle for gating `reg_wr_en`/`dat_wr_en`.
- Start latency:
  - `start` sampled at edge N.
  - `pc_out`=0 and `run`=1 during cycle N+1.
- Jumps: next address takes effect on the next edge, so there is no branch delay slot and no bubble.
- LUT write: visible to a jump read on the cycle after the write edge.
- `done` rises on the edge after the halt cycle.

## Test plan
- **Reset and start:** assert `reset` mid-clock, then deassert. Required: `pc_out`=0, `done`=0, `run`=0, LUT[5]=0. Pulse `start` -> next cycle `pc_out`=0 and `run`=1; following cycles `pc_out` = 1, 2, 3.
- **Jump via LUT:** write LUT[3]=0x120, then run. At pc=4 assert `pc_jmp_en` with `lut_ptr`=3 -> next `pc_out`=0x120. Same-cycle rewrite of LUT[3]=0x200 -> the jump still lands on 0x120.
- **Load stall (LOAD_LAT=2):** `mem_rd` at pc=7 -> `run`=0 for 3 cycles with pc held at 7, then `run`=1 for one cycle, then pc=8. `cycles` advances by 4 across the load.
- **Halt and restart:** `halt_instr` at pc=9 with `pc_jmp_en`=1 -> no jump; `done`=1 next cycle; `pc_out`=9 held. `start` in DONE -> `pc_out`=0, `done`=0, `cycles`=0. `start` pulsed during RUN -> no effect.
- **Wrap and saturation:** with PC_W=4, run from 0 with no jumps -> pc 15 is followed by 0. Run 70000 cycles without halt -> `cycles` stays at 0xFFFF.
- **Reset during WAIT:** assert `reset` with the counter at 1 -> state IDLE, `ld_done`=0, `run`=0, `pc_out`=0. Next `start` executes normally from 0.
